pcm_stream_player: RTL and testbench
====================================

// Module: pcm_stream_player
// PURPOSE
// - Multi-channel PCM sample streamer; parametrised successor of the single-channel theme playback counter.
// - Each channel fetches words from SDRAM/ROM through one shared request/ack port, buffers them in a per-channel FIFO,
//   and emits one sample per channel on each common sample tick (clk_sys / DIV).
// - Adds start/end address, loop mode, stop, restart, round-robin arbitration and underrun reporting.
// PARAMETERS
// CH       2    number of channels (1..8)
// AW       18   word address width
// DW       16   sample/data width
// DIV      150  clk_sys cycles per sample tick (96 MHz / 150 = 640 kHz)
// FDEPTH   4    FIFO words per channel (power of 2, >= 2)
// PORTS
// clk_sys        in   1       system clock
// nRESET         in   1       async active-low reset
// ch_start       in   CH      1-cycle pulse per channel: (re)start playback
// ch_stop        in   CH      1-cycle pulse per channel: stop playback
// ch_loop        in   CH      level, sampled at start: 1 = loop at end_addr
// start_addr     in   CH*AW   per-channel first word address, sampled at start
// end_addr       in   CH*AW   per-channel last word address (inclusive), sampled at start
// mem_req        out  1       request to memory; held until mem_ack
// mem_addr       out  AW      word address; stable while mem_req=1
// mem_ack        in   1       1-cycle pulse, mem_data valid in the same cycle
// mem_data       in   DW      read data
// sample_out     out  CH*DW   per-channel current sample
// sample_strobe  out  1       1-cycle pulse on each sample tick, coincident with sample_out update
// ch_busy        out  CH      channel in PLAY state
// underrun       out  CH      1-cycle pulse: channel was PLAY with empty FIFO at a tick
// BEHAVIOUR
// - Reset: all outputs 0; divider 0; all channels IDLE; FIFOs empty; no request outstanding; RR pointer at channel 0.
// - Divider: free-running 0..DIV-1 from reset; tick when divider == DIV-1, then wraps to 0.
//   sample_strobe is registered: it goes high the cycle after the tick, together with updated sample_out.
// - Channel FSM: IDLE -> PLAY on ch_start. In PLAY: fetch_ptr loads start_addr; loop and end are latched.
//   PLAY -> IDLE on ch_stop, or at a tick when fetch_done=1 and the FIFO is empty.
//   ch_start while in PLAY restarts: FIFO flushed, pointers reloaded, fetch_done cleared.
//   ch_start and ch_stop in the same cycle: stop wins.
// - Fetch pointer: advances +1 mod 2^AW on each accepted ack. When the acked address == end: if loop, reload start;
//   else set fetch_done. end < start therefore wraps through 2^AW. start == end plays a single word.
// - Arbitration: when no request is outstanding, select the next channel after the last grant (round-robin) that is
//   PLAY, not fetch_done, and has FIFO count + outstanding < FDEPTH. mem_req rises the cycle after selection, with
//   mem_addr = that channel's fetch_ptr and grant tag = channel index.
// - Handshake: mem_req and mem_addr are held until mem_ack. mem_req drops in the ack cycle + 1. One outstanding
//   request maximum. mem_ack while mem_req=0 is ignored.
// - Discard: if the tagged channel was stopped or restarted while its request was outstanding, the ack completes
//   the handshake but the data is dropped and the fetch pointer is not advanced.
// - Output at tick, per channel:
//   - IDLE: sample_out = 0.
//   - PLAY with FIFO non-empty: pop one word to sample_out.
//   - PLAY with FIFO empty and fetch_done=0: hold previous sample, pulse underrun.
//   - PLAY with FIFO empty and fetch_done=1: go IDLE, sample_out = 0, no underrun.
// - FIFO push and pop in the same cycle: both take effect, count unchanged. Push is never attempted when full
//   (guaranteed by arbitration).
// - ch_busy = (state == PLAY), registered. All state except reset is synchronous to clk_sys.
// TESTING
// - Reset mid-request (mem_req=1) -> mem_req=0, ch_busy=0, sample_out=0 immediately. After release, divider
//   restarts and the first strobe arrives DIV+1 cycles later.
// - CH0 start=0x100, end=0x103, loop=0; mem with 2-cycle ack latency returning data=addr -> strobes emit
//   0x100..0x103, then 0. ch_busy falls at the 5th tick. No underrun.
// - Same as above with loop=1 -> sequence 0x100..0x103,0x100,... repeats indefinitely. mem_addr wraps 0x103 -> 0x100.
// - CH0 and CH1 both playing, ack latency 1 -> mem_req grants alternate 0,1,0,1. Each FIFO reaches FDEPTH and
//   mem_req then stays low until a tick pops.
// - Ack latency forced > DIV -> underrun pulses on the tick and sample_out holds the last value.
//   ch_stop during an outstanding request -> ack data dropped and the FIFO stays empty.
// - start=0x3FFFE, end=0x00001 (AW=18) -> addresses 3FFFE, 3FFFF, 00000, 00001, then done.
//   Simultaneous ch_start and ch_stop -> channel remains IDLE.

Source files
------------

// File: rtl/pcm_stream_player_if.sv
// Shared memory read port used by pcm_stream_player.
// The master (player) raises mem_req with a stable mem_addr and holds both until the slave
// (SDRAM/ROM controller) returns a one-cycle mem_ack with mem_data valid in that same cycle.
//   mem_req   master -> slave   read request, held until acknowledged
//   mem_addr  master -> slave   word address, stable while mem_req = 1
//   mem_ack   slave  -> master  one-cycle acknowledge
//   mem_data  slave  -> master  read data, valid with mem_ack
interface pcm_stream_player_if #(
    parameter int unsigned AW = 18,
    parameter int unsigned DW = 16
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_data;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/pcm_stream_player.sv
// Multi-channel PCM sample streamer.
// Each channel fetches words between its start and end address through one shared memory
// port (round-robin, one request outstanding), buffers them in a small per-channel FIFO and
// emits one sample per channel on every common sample tick (every DIV clk_sys cycles).
// Ports:
//   clk_sys          system clock
//   nRESET           asynchronous active-low reset
//   ch_start_i       per-channel one-cycle (re)start pulse
//   ch_stop_i        per-channel one-cycle stop pulse (wins over start)
//   ch_loop_i        per-channel loop enable, sampled at start
//   start_addr_i     per-channel first word address, sampled at start
//   end_addr_i       per-channel last word address (inclusive), sampled at start
//   mem              shared memory read port (master side)
//   sample_out_o     per-channel current sample
//   sample_strobe_o  one-cycle pulse together with each sample_out_o update
//   ch_busy_o        per-channel playing flag
//   underrun_o       per-channel one-cycle pulse: tick found a playing channel starved
module pcm_stream_player #(
    parameter int unsigned CH     = 2,
    parameter int unsigned AW     = 18,
    parameter int unsigned DW     = 16,
    parameter int unsigned DIV    = 150,
    parameter int unsigned FDEPTH = 4
) (
    input  logic                clk_sys,
    input  logic                nRESET,
    input  logic [CH-1:0]       ch_start_i,
    input  logic [CH-1:0]       ch_stop_i,
    input  logic [CH-1:0]       ch_loop_i,
    input  logic [CH*AW-1:0]    start_addr_i,
    input  logic [CH*AW-1:0]    end_addr_i,
    pcm_stream_player_if.master mem,
    output logic [CH*DW-1:0]    sample_out_o,
    output logic                sample_strobe_o,
    output logic [CH-1:0]       ch_busy_o,
    output logic [CH-1:0]       underrun_o
);
    localparam int unsigned CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned DIVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PW   = $clog2(FDEPTH);

    typedef enum logic {StIdle, StPlay} state_e;

    // Sample tick divider
    logic [DIVW-1:0] div_q, div_d;
    logic            tick, strobe_q;

    // Request / arbitration state
    logic            req_q, req_d, drop_q, drop_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   tag_q, tag_d, rr_q, rr_d, sel_ch;
    logic            sel_vld;

    // Per-channel state
    state_e          state_q [CH], state_d [CH];
    logic [AW-1:0]   fptr_q  [CH], fptr_d  [CH];
    logic [AW-1:0]   saddr_q [CH], saddr_d [CH];
    logic [AW-1:0]   eaddr_q [CH], eaddr_d [CH];
    logic [PW-1:0]   rdp_q   [CH], rdp_d   [CH];
    logic [PW-1:0]   wrp_q   [CH], wrp_d   [CH];
    logic [PW:0]     cnt_q   [CH], cnt_d   [CH];
    logic [DW-1:0]   smp_q   [CH], smp_d   [CH];
    logic [DW-1:0]   fifo_q  [CH][FDEPTH];
    logic [CH-1:0]   loop_q, loop_d, done_q, done_d, und_q, und_d;
    logic [CH-1:0]   push, pop;

    assign tick  = (div_q == DIVW'(DIV - 1));
    assign div_d = tick ? '0 : div_q + DIVW'(1);

    // Round-robin search starting at rr_q (the channel after the last grant).
    always_comb begin
        logic [CW-1:0] idx;
        sel_vld = 1'b0;
        sel_ch  = '0;
        idx     = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            idx = CW'((32'(rr_q) + i) % CH);
            if (!sel_vld && state_q[idx] == StPlay && !done_q[idx] &&
                cnt_q[idx] < (PW+1)'(FDEPTH)) begin
                sel_vld = 1'b1;
                sel_ch  = idx;
            end
        end
    end

    always_comb begin
        req_d  = req_q;
        addr_d = addr_q;
        tag_d  = tag_q;
        drop_d = drop_q;
        rr_d   = rr_q;
        if (req_q) begin
            // A stop/restart of the owner makes the in-flight word stale.
            if (ch_start_i[tag_q] || ch_stop_i[tag_q]) drop_d = 1'b1;
            if (mem.mem_ack) req_d = 1'b0;
        end else if (sel_vld) begin
            req_d  = 1'b1;
            addr_d = fptr_q[sel_ch];
            tag_d  = sel_ch;
            drop_d = ch_start_i[sel_ch] | ch_stop_i[sel_ch];
            rr_d   = CW'((32'(sel_ch) + 1) % CH);
        end
    end

    always_comb begin
        push = '0;
        pop  = '0;
        for (int c = 0; c < CH; c++) begin
            state_d[c] = state_q[c];
            fptr_d[c]  = fptr_q[c];
            saddr_d[c] = saddr_q[c];
            eaddr_d[c] = eaddr_q[c];
            rdp_d[c]   = rdp_q[c];
            wrp_d[c]   = wrp_q[c];
            smp_d[c]   = smp_q[c];
            loop_d[c]  = loop_q[c];
            done_d[c]  = done_q[c];
            und_d[c]   = 1'b0;

            push[c] = req_q && mem.mem_ack && !drop_q && (tag_q == CW'(c));

            if (tick) begin
                if (state_q[c] == StIdle) begin
                    smp_d[c] = '0;
                end else if (cnt_q[c] != '0) begin
                    pop[c]   = 1'b1;
                    smp_d[c] = fifo_q[c][rdp_q[c]];
                end else if (!done_q[c]) begin
                    und_d[c] = 1'b1;
                end else begin
                    state_d[c] = StIdle;
                    smp_d[c]   = '0;
                end
            end

            if (push[c]) begin
                wrp_d[c] = wrp_q[c] + PW'(1);
                if (fptr_q[c] == eaddr_q[c] && loop_q[c]) begin
                    fptr_d[c] = saddr_q[c];
                end else begin
                    fptr_d[c] = fptr_q[c] + AW'(1);
                    if (fptr_q[c] == eaddr_q[c]) done_d[c] = 1'b1;
                end
            end
            if (pop[c]) rdp_d[c] = rdp_q[c] + PW'(1);
            cnt_d[c] = cnt_q[c] + (PW+1)'(push[c]) - (PW+1)'(pop[c]);

            if (ch_stop_i[c]) begin
                state_d[c] = StIdle;
                done_d[c]  = 1'b0;
                rdp_d[c]   = '0;
                wrp_d[c]   = '0;
                cnt_d[c]   = '0;
            end else if (ch_start_i[c]) begin
                state_d[c] = StPlay;
                fptr_d[c]  = start_addr_i[c*AW +: AW];
                saddr_d[c] = start_addr_i[c*AW +: AW];
                eaddr_d[c] = end_addr_i[c*AW +: AW];
                loop_d[c]  = ch_loop_i[c];
                done_d[c]  = 1'b0;
                rdp_d[c]   = '0;
                wrp_d[c]   = '0;
                cnt_d[c]   = '0;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            div_q    <= '0;
            strobe_q <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            tag_q    <= '0;
            drop_q   <= 1'b0;
            rr_q     <= '0;
            loop_q   <= '0;
            done_q   <= '0;
            und_q    <= '0;
            for (int c = 0; c < CH; c++) begin
                state_q[c] <= StIdle;
                fptr_q[c]  <= '0;
                saddr_q[c] <= '0;
                eaddr_q[c] <= '0;
                rdp_q[c]   <= '0;
                wrp_q[c]   <= '0;
                cnt_q[c]   <= '0;
                smp_q[c]   <= '0;
            end
        end else begin
            div_q    <= div_d;
            strobe_q <= tick;
            req_q    <= req_d;
            addr_q   <= addr_d;
            tag_q    <= tag_d;
            drop_q   <= drop_d;
            rr_q     <= rr_d;
            loop_q   <= loop_d;
            done_q   <= done_d;
            und_q    <= und_d;
            state_q  <= state_d;
            fptr_q   <= fptr_d;
            saddr_q  <= saddr_d;
            eaddr_q  <= eaddr_d;
            rdp_q    <= rdp_d;
            wrp_q    <= wrp_d;
            cnt_q    <= cnt_d;
            smp_q    <= smp_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk_sys) begin
        for (int c = 0; c < CH; c++) begin
            if (push[c]) fifo_q[c][wrp_q[c]] <= mem.mem_data;
        end
    end

    assign mem.mem_req      = req_q;
    assign mem.mem_addr     = addr_q;
    assign sample_strobe_o  = strobe_q;
    assign underrun_o       = und_q;

    always_comb begin
        sample_out_o = '0;
        ch_busy_o    = '0;
        for (int c = 0; c < CH; c++) begin
            sample_out_o[c*DW +: DW] = smp_q[c];
            ch_busy_o[c]             = (state_q[c] == StPlay);
        end
    end
endmodule

// File: tb/tb_pcm_stream_player.sv
// Directed bench for pcm_stream_player: reset behaviour, single-shot and looped playback,
// two-channel round-robin with full FIFOs, underrun with a stalled memory, stop with a
// request in flight, address wrap through 2^AW and start/stop collision.
module tb_pcm_stream_player;
    localparam int unsigned CH     = 2;
    localparam int unsigned AW     = 18;
    localparam int unsigned DW     = 16;
    localparam int unsigned DIV    = 40;
    localparam int unsigned FDEPTH = 4;

    logic             clk_sys = 1'b0;
    logic             nRESET  = 1'b0;
    logic [CH-1:0]    ch_start, ch_stop, ch_loop;
    logic [CH*AW-1:0] start_addr, end_addr;
    logic [CH*DW-1:0] sample_out;
    logic             sample_strobe;
    logic [CH-1:0]    ch_busy, underrun;

    int tests = 0;
    int fails = 0;

    pcm_stream_player_if #(.AW(AW), .DW(DW)) mem_bus ();

    pcm_stream_player #(
        .CH(CH), .AW(AW), .DW(DW), .DIV(DIV), .FDEPTH(FDEPTH)
    ) dut (
        .clk_sys        (clk_sys),
        .nRESET         (nRESET),
        .ch_start_i     (ch_start),
        .ch_stop_i      (ch_stop),
        .ch_loop_i      (ch_loop),
        .start_addr_i   (start_addr),
        .end_addr_i     (end_addr),
        .mem            (mem_bus),
        .sample_out_o   (sample_out),
        .sample_strobe_o(sample_strobe),
        .ch_busy_o      (ch_busy),
        .underrun_o     (underrun)
    );

    always #5 clk_sys = ~clk_sys;

    // Memory model: ack 'lat' cycles after mem_req rises, data = low DW bits of address.
    int lat      = 2;
    bit mem_hold = 1'b0;
    int wait_cnt = 0;
    always @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            mem_bus.mem_ack  <= 1'b0;
            mem_bus.mem_data <= '0;
            wait_cnt         <= 0;
        end else if (mem_bus.mem_ack) begin
            mem_bus.mem_ack <= 1'b0;
        end else if (mem_bus.mem_req && !mem_hold) begin
            if (wait_cnt >= lat - 1) begin
                mem_bus.mem_ack  <= 1'b1;
                mem_bus.mem_data <= mem_bus.mem_addr[DW-1:0];
                wait_cnt         <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else if (!mem_bus.mem_req) begin
            wait_cnt <= 0;
        end
    end

    // Log the address of every new request.
    logic [AW-1:0] addr_log [$];
    logic          req_prev = 1'b0;
    always @(negedge clk_sys) begin
        if (mem_bus.mem_req && !req_prev) addr_log.push_back(mem_bus.mem_addr);
        req_prev <= mem_bus.mem_req;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (sample_strobe !== 1'b1 && n < 2 * DIV);
        check(tag, 64'(sample_strobe), 64'd1);
    endtask

    task automatic pulse(input logic [CH-1:0] st, input logic [CH-1:0] sp);
        ch_start = st;
        ch_stop  = sp;
        @(negedge clk_sys);
        ch_start = '0;
        ch_stop  = '0;
    endtask

    task automatic set_ch(input int c, input logic [AW-1:0] s, input logic [AW-1:0] e,
                          input logic l);
        start_addr[c*AW +: AW] = s;
        end_addr[c*AW +: AW]   = e;
        ch_loop[c]             = l;
    endtask

    logic [AW-1:0] exp_c [8];
    logic [AW-1:0] exp_w [4];

    initial begin
        int n;
        int base;
        ch_start = '0; ch_stop = '0; ch_loop = '0; start_addr = '0; end_addr = '0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        check("rst_req", 64'(mem_bus.mem_req), 0);
        check("rst_addr", 64'(mem_bus.mem_addr), 0);
        check("rst_strobe", 64'(sample_strobe), 0);
        check("rst_sample", 64'(sample_out), 0);
        check("rst_busy", 64'(ch_busy), 0);
        check("rst_underrun", 64'(underrun), 0);

        // Reset while a request is outstanding
        nRESET = 1'b1;
        mem_hold = 1'b1;
        set_ch(0, 18'h100, 18'h103, 1'b0);
        pulse(2'b01, 2'b00);
        n = 0;
        while (mem_bus.mem_req !== 1'b1 && n < 10) begin @(negedge clk_sys); n++; end
        check("midreq_req_up", 64'(mem_bus.mem_req), 1);
        nRESET = 1'b0;
        #1;
        check("midreq_req", 64'(mem_bus.mem_req), 0);
        check("midreq_busy", 64'(ch_busy), 0);
        check("midreq_sample", 64'(sample_out), 0);
        mem_hold = 1'b0;
        @(negedge clk_sys);
        nRESET = 1'b1;
        // Divider restarts at 0: the strobe is high in the (DIV+1)-th cycle, i.e. after DIV edges.
        n = 0;
        do begin @(negedge clk_sys); n++; end while (sample_strobe !== 1'b1 && n < 3 * DIV);
        check("first_strobe_edges", 64'(n), 64'(DIV));

        // Two channels, ack latency 1: alternate grants, FIFOs fill, port goes quiet
        lat = 1;
        set_ch(0, 18'h100, 18'h1FF, 1'b0);
        set_ch(1, 18'h200, 18'h2FF, 1'b0);
        base = addr_log.size();
        pulse(2'b11, 2'b00);
        check("rr_busy", 64'(ch_busy), 2'b11);
        n = 0;
        while ((addr_log.size() < base + 8 || mem_bus.mem_req !== 1'b0) && n < 35) begin
            @(negedge clk_sys); n++;
        end
        exp_c = '{18'h100, 18'h200, 18'h101, 18'h201, 18'h102, 18'h202, 18'h103, 18'h203};
        check("rr_count", 64'(addr_log.size() - base), 8);
        for (int k = 0; k < 8 && base + k < addr_log.size(); k++)
            check($sformatf("rr_addr%0d", k), 64'(addr_log[base+k]), 64'(exp_c[k]));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_sys);
            check("full_no_req", 64'(mem_bus.mem_req), 0);
        end
        wait_strobe("rr_strobe1");
        check("rr_ch0_s1", 64'(sample_out[15:0]), 18'h100);
        check("rr_ch1_s1", 64'(sample_out[31:16]), 18'h200);
        n = 0;
        while (addr_log.size() < base + 10 && n < 20) begin @(negedge clk_sys); n++; end
        check("rr_refill_cnt", 64'(addr_log.size() - base), 10);
        if (addr_log.size() >= base + 10) begin
            check("rr_refill0", 64'(addr_log[base+8]), 18'h104);
            check("rr_refill1", 64'(addr_log[base+9]), 18'h204);
        end
        pulse(2'b00, 2'b11);
        check("rr_stop_busy", 64'(ch_busy), 0);
        wait_strobe("rr_strobe2");
        check("rr_stop_sample", 64'(sample_out), 0);

        // Single shot 0x100..0x103, ack latency 2
        lat = 2;
        set_ch(0, 18'h100, 18'h103, 1'b0);
        base = addr_log.size();
        pulse(2'b01, 2'b00);
        check("once_busy", 64'(ch_busy), 2'b01);
        for (int k = 0; k < 4; k++) begin
            wait_strobe("once_strobe");
            check($sformatf("once_s%0d", k), 64'(sample_out[15:0]), 64'(18'h100 + k));
            check("once_underrun", 64'(underrun), 0);
            check("once_busy_k", 64'(ch_busy), 2'b01);
        end
        wait_strobe("once_strobe5");
        check("once_end_sample", 64'(sample_out), 0);
        check("once_end_busy", 64'(ch_busy), 0);
        check("once_end_underrun", 64'(underrun), 0);
        check("once_req_count", 64'(addr_log.size() - base), 4);

        // Looped 0x100..0x103
        set_ch(0, 18'h100, 18'h103, 1'b1);
        base = addr_log.size();
        pulse(2'b01, 2'b00);
        for (int k = 0; k < 10; k++) begin
            wait_strobe("loop_strobe");
            check($sformatf("loop_s%0d", k), 64'(sample_out[15:0]), 64'(18'h100 + (k % 4)));
            check("loop_underrun", 64'(underrun), 0);
        end
        check("loop_busy", 64'(ch_busy), 2'b01);
        for (int k = 0; k < 6; k++)
            check($sformatf("loop_addr%0d", k), 64'(addr_log[base+k]), 64'(18'h100 + (k % 4)));
        pulse(2'b00, 2'b01);
        wait_strobe("loop_stop_strobe");
        check("loop_stop_sample", 64'(sample_out), 0);
        check("loop_stop_busy", 64'(ch_busy), 0);

        // Stalled memory: underrun with held sample, then stop with request in flight
        set_ch(0, 18'h300, 18'h3FF, 1'b0);
        pulse(2'b01, 2'b00);
        wait_strobe("ur_strobe0");
        check("ur_s0", 64'(sample_out[15:0]), 18'h300);
        mem_hold = 1'b1;
        for (int k = 1; k < 4; k++) begin
            wait_strobe("ur_strobe");
            check($sformatf("ur_s%0d", k), 64'(sample_out[15:0]), 64'(18'h300 + k));
            check("ur_none_yet", 64'(underrun), 0);
        end
        wait_strobe("ur_strobe4");
        check("ur_pulse1", 64'(underrun), 2'b01);
        check("ur_hold1", 64'(sample_out[15:0]), 18'h303);
        check("ur_busy", 64'(ch_busy), 2'b01);
        check("ur_req_held", 64'(mem_bus.mem_req), 1);
        check("ur_addr_held", 64'(mem_bus.mem_addr), 18'h304);
        @(negedge clk_sys);
        check("ur_pulse_width", 64'(underrun), 0);
        wait_strobe("ur_strobe5");
        check("ur_pulse2", 64'(underrun), 2'b01);
        check("ur_hold2", 64'(sample_out[15:0]), 18'h303);
        pulse(2'b00, 2'b01);
        mem_hold = 1'b0;
        n = 0;
        while (mem_bus.mem_req !== 1'b0 && n < 10) begin @(negedge clk_sys); n++; end
        check("drop_ack_done", 64'(mem_bus.mem_req), 0);
        wait_strobe("drop_strobe");
        check("drop_sample", 64'(sample_out), 0);
        check("drop_busy", 64'(ch_busy), 0);
        check("drop_underrun", 64'(underrun), 0);
        // Single word start == end; stale 0x304 must not appear
        set_ch(0, 18'h500, 18'h500, 1'b0);
        base = addr_log.size();
        pulse(2'b01, 2'b00);
        wait_strobe("single_strobe1");
        check("single_s", 64'(sample_out[15:0]), 18'h500);
        wait_strobe("single_strobe2");
        check("single_end_sample", 64'(sample_out), 0);
        check("single_end_busy", 64'(ch_busy), 0);
        check("single_req_count", 64'(addr_log.size() - base), 1);

        // Address wrap through 2^AW
        set_ch(0, 18'h3FFFE, 18'h00001, 1'b0);
        base = addr_log.size();
        pulse(2'b01, 2'b00);
        exp_w = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
        for (int k = 0; k < 4; k++) begin
            wait_strobe("wrap_strobe");
            check($sformatf("wrap_s%0d", k), 64'(sample_out[15:0]), 64'(exp_w[k][15:0]));
        end
        check("wrap_busy4", 64'(ch_busy), 2'b01);
        wait_strobe("wrap_strobe5");
        check("wrap_end_busy", 64'(ch_busy), 0);
        check("wrap_end_sample", 64'(sample_out), 0);
        check("wrap_req_count", 64'(addr_log.size() - base), 4);
        for (int k = 0; k < 4 && base + k < addr_log.size(); k++)
            check($sformatf("wrap_addr%0d", k), 64'(addr_log[base+k]), 64'(exp_w[k]));

        // Start and stop together: stop wins
        set_ch(1, 18'h600, 18'h600, 1'b0);
        pulse(2'b10, 2'b10);
        check("collide_busy", 64'(ch_busy), 0);
        repeat (3) @(negedge clk_sys);
        check("collide_no_req", 64'(mem_bus.mem_req), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
